// File: rtl/move_scheduler_if.sv
// Collision-unit bus shared by the move scheduler (master) and the
// block-collision checker (slave).
interface move_scheduler_if;
    logic       col_req;
    logic       col_id;
    logic [9:0] col_x;
    logic [9:0] col_y;
    logic       col_ack;
    logic       col_hit;

    modport master (
        output col_req, col_id, col_x, col_y,
        input  col_ack, col_hit
    );

    modport slave (
        input  col_req, col_id, col_x, col_y,
        output col_ack, col_hit
    );
endinterface

// File: rtl/move_scheduler.sv
// move_scheduler: once per frame, snapshots both players' proposed positions
// and runs them one after the other through the shared collision unit,
// producing a one-cycle commit or block pulse per player.
//
// Build option: define MOVE_SCHED_RR_EN to alternate which player is served
// first on each frame. Without it, P1 is always served first.
//
// state  | meaning
// -------+----------------------------------------------------------------
// IDLE   | waiting for frame_tick, collision bus idle
// FIRST  | serving player first_sel (one gap cycle never occurs here)
// SECOND | serving the other player; first cycle is a bus gap after FIRST
module move_scheduler #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                    Clk,
    input  logic                    Reset_n,
    input  logic                    frame_tick,
    input  logic [9:0]              p1_x,
    input  logic [9:0]              p1_y,
    input  logic [9:0]              p2_x,
    input  logic [9:0]              p2_y,
    move_scheduler_if.master        col,
    output logic                    p1_commit,
    output logic                    p2_commit,
    output logic                    p1_block,
    output logic                    p2_block,
    output logic                    busy,
    output logic                    overrun,
    output logic                    timeout_err
);

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FIRST  = 2'd1,
        SECOND = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic       first_sel_q, first_sel_d;
    logic       gap_q, gap_d;
    logic [7:0] cnt_q, cnt_d;
    logic [9:0] s1x_q, s1x_d, s1y_q, s1y_d, s2x_q, s2x_d, s2y_q, s2y_d;
    logic       p1_commit_q, p1_commit_d, p2_commit_q, p2_commit_d;
    logic       p1_block_q, p1_block_d, p2_block_q, p2_block_d;
    logic       overrun_q, overrun_d;
    logic       timeout_err_q, timeout_err_d;

    logic       served;
    logic       req;
    logic       tmo;
    logic       done;
    logic       hit;

    // SECOND serves whichever player FIRST did not; the gap cycle keeps
    // col_req low between the two requests.
    assign served = (state_q == SECOND) ? ~first_sel_q : first_sel_q;
    assign req    = (state_q != IDLE) && !gap_q;
    assign tmo    = req && (cnt_q == TIMEOUT_CNT);
    assign done   = req && (tmo || col.col_ack);
    assign hit    = tmo || col.col_hit;

    // Next-state, counter, snapshot and pulse logic.
    always_comb begin
        state_d       = state_q;
        first_sel_d   = first_sel_q;
        gap_d         = 1'b0;
        cnt_d         = cnt_q;
        s1x_d         = s1x_q;
        s1y_d         = s1y_q;
        s2x_d         = s2x_q;
        s2y_d         = s2y_q;
        overrun_d     = overrun_q;
        timeout_err_d = timeout_err_q;
        p1_commit_d   = done && !served && !hit;
        p2_commit_d   = done &&  served && !hit;
        p1_block_d    = done && !served &&  hit;
        p2_block_d    = done &&  served &&  hit;

        if (frame_tick && (state_q != IDLE)) begin
            overrun_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (frame_tick) begin
                    s1x_d   = p1_x;
                    s1y_d   = p1_y;
                    s2x_d   = p2_x;
                    s2y_d   = p2_y;
                    state_d = FIRST;
                end
            end
            FIRST, SECOND: begin
                if (done) begin
                    cnt_d = '0;
                    if (tmo) begin
                        timeout_err_d = 1'b1;
                    end
                    if (state_q == FIRST) begin
                        state_d = SECOND;
                        gap_d   = 1'b1;
                    end else begin
                        state_d = IDLE;
`ifdef MOVE_SCHED_RR_EN
                        first_sel_d = ~first_sel_q;
`else
                        first_sel_d = 1'b0;
`endif
                    end
                end else if (req) begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any in-flight request.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q       <= IDLE;
            first_sel_q   <= 1'b0;
            gap_q         <= 1'b0;
            cnt_q         <= '0;
            s1x_q         <= '0;
            s1y_q         <= '0;
            s2x_q         <= '0;
            s2y_q         <= '0;
            p1_commit_q   <= 1'b0;
            p2_commit_q   <= 1'b0;
            p1_block_q    <= 1'b0;
            p2_block_q    <= 1'b0;
            overrun_q     <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            first_sel_q   <= first_sel_d;
            gap_q         <= gap_d;
            cnt_q         <= cnt_d;
            s1x_q         <= s1x_d;
            s1y_q         <= s1y_d;
            s2x_q         <= s2x_d;
            s2y_q         <= s2y_d;
            p1_commit_q   <= p1_commit_d;
            p2_commit_q   <= p2_commit_d;
            p1_block_q    <= p1_block_d;
            p2_block_q    <= p2_block_d;
            overrun_q     <= overrun_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign col.col_req  = req;
    assign col.col_id   = req & served;
    assign col.col_x    = !req ? 10'd0 : (served ? s2x_q : s1x_q);
    assign col.col_y    = !req ? 10'd0 : (served ? s2y_q : s1y_q);

    assign p1_commit   = p1_commit_q;
    assign p2_commit   = p2_commit_q;
    assign p1_block    = p1_block_q;
    assign p2_block    = p2_block_q;
    assign busy        = (state_q != IDLE);
    assign overrun     = overrun_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_move_scheduler.sv
module tb_move_scheduler;

    logic       Clk = 1'b0;
    logic       Reset_n;
    logic       frame_tick;
    logic [9:0] p1_x, p1_y, p2_x, p2_y;
    logic       p1_commit, p2_commit, p1_block, p2_block;
    logic       busy, overrun, timeout_err;

    int pass_cnt  = 0;
    int total_cnt = 0;
    bit exp_first = 1'b0;

    move_scheduler_if bus();

    move_scheduler #(.TIMEOUT(4)) dut (
        .Clk         (Clk),
        .Reset_n     (Reset_n),
        .frame_tick  (frame_tick),
        .p1_x        (p1_x),
        .p1_y        (p1_y),
        .p2_x        (p2_x),
        .p2_y        (p2_y),
        .col         (bus),
        .p1_commit   (p1_commit),
        .p2_commit   (p2_commit),
        .p1_block    (p1_block),
        .p2_block    (p2_block),
        .busy        (busy),
        .overrun     (overrun),
        .timeout_err (timeout_err)
    );

    always #5 Clk = ~Clk;

    logic [3:0]  pulses;
    logic [21:0] req_vec;
    logic [30:0] all_outs;
    assign pulses   = {p1_commit, p2_commit, p1_block, p2_block};
    assign req_vec  = {bus.col_req, bus.col_id, bus.col_x, bus.col_y};
    assign all_outs = {req_vec, pulses, busy, overrun, timeout_err};

    function automatic logic [3:0] commit_pulse(input bit s);
        return s ? 4'b0100 : 4'b1000;
    endfunction

    function automatic logic [3:0] block_pulse(input bit s);
        return s ? 4'b0001 : 4'b0010;
    endfunction

    task automatic step();
        @(posedge Clk);
        @(negedge Clk);
    endtask

    task automatic next_frame_order();
`ifdef MOVE_SCHED_RR_EN
        exp_first = ~exp_first;
`else
        exp_first = 1'b0;
`endif
    endtask

    task automatic start_frame(input logic [9:0] ax, ay, bx, by);
        p1_x = ax; p1_y = ay; p2_x = bx; p2_y = by;
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
    endtask

    task automatic test_reset();
        Reset_n = 1'b0;
        frame_tick = 1'b0;
        bus.col_ack = 1'b0;
        bus.col_hit = 1'b0;
        p1_x = '0; p1_y = '0; p2_x = '0; p2_y = '0;
        #2;
        total_cnt++;
        if (all_outs !== 31'd0) $display("FAIL reset_async: got %h expected 0", all_outs);
        else pass_cnt++;
        step();
        step();
        Reset_n = 1'b1;
        step();
        total_cnt++;
        if (all_outs !== 31'd0) $display("FAIL reset_idle: got %h expected 0", all_outs);
        else pass_cnt++;
        exp_first = 1'b0;
    endtask

    task automatic test_basic();
        start_frame(10'd100, 10'd200, 10'd300, 10'd50);
        total_cnt++;
        if (req_vec !== {1'b1, 1'b0, 10'd100, 10'd200} || busy !== 1'b1)
            $display("FAIL basic_req1: got %h busy %b expected %h busy 1", req_vec, busy, {1'b1, 1'b0, 10'd100, 10'd200});
        else pass_cnt++;
        step();
        total_cnt++;
        if (req_vec !== {1'b1, 1'b0, 10'd100, 10'd200} || pulses !== 4'b0000)
            $display("FAIL basic_hold1: got %h pulses %b", req_vec, pulses);
        else pass_cnt++;
        bus.col_ack = 1'b1; bus.col_hit = 1'b0;
        step();
        bus.col_ack = 1'b0;
        total_cnt++;
        if (pulses !== 4'b1000 || bus.col_req !== 1'b0 || busy !== 1'b1)
            $display("FAIL basic_p1: got pulses %b req %b busy %b expected 1000 0 1", pulses, bus.col_req, busy);
        else pass_cnt++;
        step();
        total_cnt++;
        if (req_vec !== {1'b1, 1'b1, 10'd300, 10'd50})
            $display("FAIL basic_req2: got %h expected %h", req_vec, {1'b1, 1'b1, 10'd300, 10'd50});
        else pass_cnt++;
        step();
        bus.col_ack = 1'b1;
        step();
        bus.col_ack = 1'b0;
        total_cnt++;
        if (pulses !== 4'b0100 || busy !== 1'b0 || bus.col_req !== 1'b0)
            $display("FAIL basic_p2: got pulses %b busy %b req %b expected 0100 0 0", pulses, busy, bus.col_req);
        else pass_cnt++;
        next_frame_order();
    endtask

    task automatic test_round_robin();
        start_frame(10'd11, 10'd22, 10'd33, 10'd44);
        total_cnt++;
        if (bus.col_id !== exp_first || bus.col_x !== (exp_first ? 10'd33 : 10'd11))
            $display("FAIL rr_first_id: got id %b x %0d expected id %b", bus.col_id, bus.col_x, exp_first);
        else pass_cnt++;
        bus.col_ack = 1'b1; bus.col_hit = 1'b0;
        step();
        bus.col_ack = 1'b0;
        total_cnt++;
        if (pulses !== commit_pulse(exp_first) || bus.col_req !== 1'b0)
            $display("FAIL rr_first_pulse: got %b req %b expected %b req 0", pulses, bus.col_req, commit_pulse(exp_first));
        else pass_cnt++;
        step();
        total_cnt++;
        if (bus.col_req !== 1'b1 || bus.col_id !== ~exp_first)
            $display("FAIL rr_second_id: got req %b id %b expected 1 %b", bus.col_req, bus.col_id, ~exp_first);
        else pass_cnt++;
        bus.col_ack = 1'b1;
        step();
        bus.col_ack = 1'b0;
        total_cnt++;
        if (pulses !== commit_pulse(~exp_first) || busy !== 1'b0)
            $display("FAIL rr_latency: got pulses %b busy %b expected %b 0", pulses, busy, commit_pulse(~exp_first));
        else pass_cnt++;
        next_frame_order();
    endtask

    task automatic test_block();
        bit f;
        f = exp_first;
        start_frame(10'd5, 10'd6, 10'd7, 10'd8);
        bus.col_ack = 1'b1; bus.col_hit = f;
        step();
        bus.col_ack = 1'b0; bus.col_hit = 1'b0;
        total_cnt++;
        if (pulses !== (f ? block_pulse(1'b1) : commit_pulse(1'b0)))
            $display("FAIL block_first: got %b expected %b", pulses, f ? block_pulse(1'b1) : commit_pulse(1'b0));
        else pass_cnt++;
        step();
        bus.col_ack = 1'b1; bus.col_hit = ~f;
        step();
        bus.col_ack = 1'b0; bus.col_hit = 1'b0;
        total_cnt++;
        if (pulses !== (f ? commit_pulse(1'b0) : block_pulse(1'b1)))
            $display("FAIL block_second: got %b expected %b", pulses, f ? commit_pulse(1'b0) : block_pulse(1'b1));
        else pass_cnt++;
        next_frame_order();
    endtask

    task automatic test_timeout();
        bit f;
        f = exp_first;
        start_frame(10'd1, 10'd2, 10'd3, 10'd4);
        for (int i = 0; i < 4; i++) begin
            total_cnt++;
            if (bus.col_req !== 1'b1 || pulses !== 4'b0000 || timeout_err !== 1'b0)
                $display("FAIL tmo_wait%0d: got req %b pulses %b err %b expected 1 0000 0", i, bus.col_req, pulses, timeout_err);
            else pass_cnt++;
            step();
        end
        total_cnt++;
        if (bus.col_req !== 1'b1 || bus.col_id !== f)
            $display("FAIL tmo_last: got req %b id %b expected 1 %b", bus.col_req, bus.col_id, f);
        else pass_cnt++;
        bus.col_ack = 1'b1; bus.col_hit = 1'b0;
        step();
        bus.col_ack = 1'b0;
        total_cnt++;
        if (pulses !== block_pulse(f) || timeout_err !== 1'b1 || bus.col_req !== 1'b0 || busy !== 1'b1)
            $display("FAIL tmo_block: got pulses %b err %b req %b busy %b expected %b 1 0 1", pulses, timeout_err, bus.col_req, busy, block_pulse(f));
        else pass_cnt++;
        step();
        total_cnt++;
        if (bus.col_req !== 1'b1 || bus.col_id !== ~f)
            $display("FAIL tmo_next: got req %b id %b expected 1 %b", bus.col_req, bus.col_id, ~f);
        else pass_cnt++;
        bus.col_ack = 1'b1;
        step();
        bus.col_ack = 1'b0;
        total_cnt++;
        if (pulses !== commit_pulse(~f) || timeout_err !== 1'b1)
            $display("FAIL tmo_sticky: got pulses %b err %b expected %b 1", pulses, timeout_err, commit_pulse(~f));
        else pass_cnt++;
        next_frame_order();
    endtask

    task automatic test_overrun();
        bit f;
        f = exp_first;
        start_frame(10'd100, 10'd101, 10'd102, 10'd103);
        frame_tick = 1'b1;
        p1_x = 10'd500; p1_y = 10'd501; p2_x = 10'd502; p2_y = 10'd503;
        step();
        frame_tick = 1'b0;
        total_cnt++;
        if (overrun !== 1'b1 || req_vec !== {1'b1, f, (f ? 10'd102 : 10'd100), (f ? 10'd103 : 10'd101)})
            $display("FAIL ovr_first: got ovr %b req %h", overrun, req_vec);
        else pass_cnt++;
        bus.col_ack = 1'b1;
        step();
        bus.col_ack = 1'b0;
        step();
        total_cnt++;
        if (req_vec !== {1'b1, ~f, (f ? 10'd100 : 10'd102), (f ? 10'd101 : 10'd103)})
            $display("FAIL ovr_second_snap: got %h", req_vec);
        else pass_cnt++;
        bus.col_ack = 1'b1;
        step();
        bus.col_ack = 1'b0;
        total_cnt++;
        if (pulses !== commit_pulse(~f) || busy !== 1'b0)
            $display("FAIL ovr_done: got pulses %b busy %b expected %b 0", pulses, busy, commit_pulse(~f));
        else pass_cnt++;
        next_frame_order();
    endtask

    task automatic test_overrun_at_end();
        Reset_n = 1'b0;
        step();
        Reset_n = 1'b1;
        exp_first = 1'b0;
        total_cnt++;
        if (overrun !== 1'b0 || timeout_err !== 1'b0)
            $display("FAIL end_reset_flags: got ovr %b err %b expected 0 0", overrun, timeout_err);
        else pass_cnt++;
        start_frame(10'd20, 10'd21, 10'd22, 10'd23);
        bus.col_ack = 1'b1;
        step();
        bus.col_ack = 1'b0;
        step();
        bus.col_ack = 1'b1;
        frame_tick = 1'b1;
        step();
        bus.col_ack = 1'b0;
        frame_tick = 1'b0;
        total_cnt++;
        if (overrun !== 1'b1 || busy !== 1'b0 || pulses !== 4'b0100)
            $display("FAIL end_tick: got ovr %b busy %b pulses %b expected 1 0 0100", overrun, busy, pulses);
        else pass_cnt++;
        step();
        total_cnt++;
        if (bus.col_req !== 1'b0 || busy !== 1'b0)
            $display("FAIL end_no_restart: got req %b busy %b expected 0 0", bus.col_req, busy);
        else pass_cnt++;
        next_frame_order();
    endtask

    task automatic test_reset_midflight();
        start_frame(10'd40, 10'd41, 10'd42, 10'd43);
        bus.col_ack = 1'b1;
        step();
        bus.col_ack = 1'b0;
        step();
        step();
        total_cnt++;
        if (bus.col_req !== 1'b1)
            $display("FAIL mid_waiting: got req %b expected 1", bus.col_req);
        else pass_cnt++;
        #1;
        Reset_n = 1'b0;
        #1;
        total_cnt++;
        if (all_outs !== 31'd0) $display("FAIL mid_async: got %h expected 0", all_outs);
        else pass_cnt++;
        bus.col_ack = 1'b1;
        step();
        bus.col_ack = 1'b0;
        total_cnt++;
        if (all_outs !== 31'd0) $display("FAIL mid_no_pulse: got %h expected 0", all_outs);
        else pass_cnt++;
        Reset_n = 1'b1;
        exp_first = 1'b0;
        step();
        start_frame(10'd7, 10'd8, 10'd9, 10'd10);
        total_cnt++;
        if (req_vec !== {1'b1, 1'b0, 10'd7, 10'd8})
            $display("FAIL mid_p1_first: got %h expected %h", req_vec, {1'b1, 1'b0, 10'd7, 10'd8});
        else pass_cnt++;
        bus.col_ack = 1'b1;
        step();
        bus.col_ack = 1'b0;
        total_cnt++;
        if (pulses !== 4'b1000)
            $display("FAIL mid_p1_commit: got %b expected 1000", pulses);
        else pass_cnt++;
        step();
        bus.col_ack = 1'b1;
        step();
        bus.col_ack = 1'b0;
        next_frame_order();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_round_robin();
        test_block();
        test_timeout();
        test_overrun();
        test_overrun_at_end();
        test_reset_midflight();
        step();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/move_scheduler.md
MOVE_SCHEDULER -- requirements
Module: move_scheduler

Interface
REQ-001 SHALL have parameter: TIMEOUT, 255, max cycles waiting for col_ack per request (1..255).
REQ-002 SHALL have ports:
- Clk  in  1  system clock; all state on rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- frame_tick  in  1  one-cycle pulse per video frame (synchronised VGA_VS edge).
- p1_x, p1_y  in  10 each  player-1 proposed next position.
- p2_x, p2_y  in  10 each  player-2 proposed next position.
- col_req  out  1  request to the shared block-collision unit.
- col_id  out  1  requester on the collision bus: 0 = P1, 1 = P2.
- col_x, col_y  out  10 each  position under test.
- col_ack  in  1  collision result valid.
- col_hit  in  1  collision result, qualified by col_ack.
- p1_commit, p2_commit  out  1 each  one-cycle pulse: move accepted.
- p1_block, p2_block  out  1 each  one-cycle pulse: move rejected.
- busy  out  1  high whenever state != IDLE.
- overrun  out  1  sticky: frame_tick arrived while busy.
- timeout_err  out  1  sticky: a request hit TIMEOUT.

Function
REQ-003 SHALL implement FSM states IDLE, FIRST, SECOND.
REQ-004 IDLE + frame_tick SHALL snapshot all four coordinates into internal registers and go to FIRST next cycle.
REQ-005 The player served in FIRST SHALL be given by register first_sel (0 = P1); SECOND SHALL serve the other player.
REQ-006 In FIRST/SECOND, col_req SHALL be 1, with col_id/col_x/col_y driven from the snapshot of the served player, held stable until the request completes.
REQ-007 A request SHALL complete on the first cycle with col_req=1 and col_ack=1; ack in the first cycle of a state is legal (minimum 1 cycle per request).
REQ-008 On completion, the served player's commit SHALL pulse if col_hit=0, and its block SHALL pulse if col_hit=1, in the cycle after completion; exactly one of the four pulses SHALL be high in that cycle.
REQ-009 On completion, FIRST SHALL go to SECOND and SECOND SHALL go to IDLE; col_req SHALL drop for at least one cycle between requests.
REQ-010 A cycle counter SHALL clear on entry to FIRST/SECOND and increment each cycle without ack; when it equals TIMEOUT, the request SHALL complete as a hit, set timeout_err, and ignore any col_ack in that cycle.
REQ-011 col_ack while col_req=0 SHALL be ignored.
REQ-012 On leaving SECOND, first_sel SHALL toggle (round-robin; see REQ-016).
REQ-013 frame_tick while busy SHALL set overrun and SHALL NOT alter the snapshot or state; frame_tick in the same cycle that SECOND completes SHALL count as overrun, and the FSM SHALL return to IDLE.
REQ-014 Best-case latency SHALL be frame_tick to last pulse = 5 cycles (snapshot, ack, pulse, gap, ack, pulse overlapping).

Reset
REQ-015 Reset_n low SHALL asynchronously force: state IDLE, first_sel 0, counter 0, snapshots 0, and all outputs 0, including the sticky flags. An in-flight request SHALL be abandoned with no commit or block pulse.

Configuration
REQ-016 Macro MOVE_SCHED_RR_EN: when defined, first_sel SHALL toggle per REQ-012. When undefined, first_sel SHALL be held at 0 and P1 SHALL always be served first.

Verification
REQ-017 Scenario: reset, frame_tick, P1=(100,200), P2=(300,50), and col_ack one cycle after each col_req with hit=0. Required: col_id sequence 0 then 1; p1_commit then p2_commit; busy low afterwards.
REQ-018 Scenario: second frame with RR enabled. Required: col_id 1 first, then 0. With the macro undefined: 0 first.
REQ-019 Scenario: P2 ack with hit=1. Required: p2_block pulses, p2_commit stays 0, and P1 is unaffected.
REQ-020 Scenario: TIMEOUT=4 and ack withheld. Required: the request completes after 4 cycles as a block, timeout_err=1, and the FSM proceeds to the next player.
REQ-021 Scenario: frame_tick during FIRST. Required: overrun=1 and the coordinates under test remain unchanged.
REQ-022 Scenario: Reset_n asserted mid-WAIT in SECOND. Required: outputs immediately 0, no pulses, and the next frame is served P1 first.
